div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle iterative integer divider for the CPU datapath (DIV/DIVU).
//  Accepts one operand pair on a start pulse and runs one restoring step per clock.
//  Returns {remainder, quotient} in the 64-bit HI/LO layout: remainder [63:32], quotient [31:0].
//  Sits between the ALU select logic and the HI/LO registers; owns its own busy/done handshake.
// PARAMETERS
//  WIDTH  32  operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clock         in   1        system clock, all state updates on rising edge
//  clear         in   1        synchronous active-high reset
//  start         in   1        request; sampled only when not busy
//  signed_op     in   1        1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//  dividend      in   WIDTH    sampled with start
//  divisor       in   WIDTH    sampled with start
//  busy          out  1        operation in progress
//  done          out  1        one-cycle pulse; result valid from this cycle
//  div_by_zero   out  1        set with done when divisor == 0; held until next accepted start
//  result        out  2*WIDTH  {remainder, quotient}; held until next accepted start
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high (clock, clear).
//  Reset: state=IDLE, busy=0, done=0, div_by_zero=0, result=0, step count=0.
//  States: IDLE -> CALC -> SIGN -> DONE -> IDLE. ZERO is a short path IDLE -> ZERO -> DONE.
//  IDLE/DONE + start=1 at edge E:
//    - latch signed_op and the operand signs.
//    - latch |dividend| and |divisor| (absolute values only when signed_op=1).
//    - remainder accumulator := 0; count := 0.
//    - go to CALC, or to ZERO if divisor == 0. busy=1 from E.
//  CALC, one step per edge:
//    - {rem,quo} shift left 1.
//    - trial = {1'b0,rem} - {1'b0,|divisor|}, computed at WIDTH+1 bits.
//    - trial >= 0: rem := trial, quo[0] := 1. Otherwise quo[0] := 0.
//    - after count == WIDTH-1, go to SIGN.
//  SIGN:
//    - quotient negated if signed_op and the operand signs differ.
//    - remainder negated if signed_op and dividend was negative; remainder takes the dividend's sign.
//    - write result; go to DONE.
//  ZERO: result := {dividend, {WIDTH{1'b1}}}, div_by_zero := 1; go to DONE.
//  DONE: done=1 and busy=0 for exactly one cycle. Without start, return to IDLE.
//  Latency, start edge to done high:
//    - normal: WIDTH+2 edges (34 at default).
//    - divide-by-zero: 2 edges.
//  start while busy is ignored: no queueing, operands not re-sampled.
//  start during DONE is accepted: back-to-back operation, done still pulses that cycle.
//  Arithmetic:
//    - magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held unsigned; the WIDTH+1 trial prevents overflow.
//    - signed -2^31 / -1 wraps: quotient 0x8000_0000, remainder 0.
//    - all negation is two's complement modulo 2^WIDTH.
//  Operand ports may change freely after the start edge; only latched copies are used.
//  clear mid-operation:
//    - next edge gives IDLE, busy=0, result=0, div_by_zero=0.
//    - no done pulse for the aborted operation.
//  clear has priority over start on the same edge.
// STRUCTURE
//  Shared package (cpu_pkg):
//    - state enum DIV_IDLE/DIV_CALC/DIV_SIGN/DIV_ZERO/DIV_DONE.
//    - WORD_W=32 constant.
//    - field select constants RES_REM_HI/RES_QUO_LO.
//  Sub-module div_step:
//    - combinational single restoring iteration.
//    - (rem, quo, divisor) -> (rem', quo'), WIDTH+1 compare.
//  Top holds FSM, counter, operand/sign latches and output registers.
// TESTING
//  1. signed 100 / 7 -> done at start+34, result = {32'd2, 32'd14}, div_by_zero=0, busy high 33 cycles.
//  2. signed -100 / 7 -> quotient 0xFFFF_FFF2, remainder 0xFFFF_FFFE.
//     signed 100 / -7 -> quotient 0xFFFF_FFF2, remainder 0x0000_0002.
//  3. 0x8000_0000 / 0xFFFF_FFFF: signed -> {0, 0x8000_0000}; unsigned -> {0x8000_0000, 0}.
//  4. divisor 0, dividend 0x1234 -> done at start+2, div_by_zero=1, result = {0x1234, 0xFFFF_FFFF}.
//  5. start with 50/5, then start with 9/3 at cycle 5 -> second start ignored, result {0, 10}.
//     Assert clear at cycle 10 of CALC -> IDLE next edge, result 0, no done pulse.
//  6. Back-to-back: start 7/2 asserted on the done cycle of 20/3.
//     -> first result {2, 6} visible at its done; second done 34 edges later with {1, 3}.

Source files
------------

// File: rtl/cpu_pkg.sv
// Purpose: constants shared by the divider datapath: word width, HI/LO result
// field offsets and the divider FSM state encodings.
package cpu_pkg;

  localparam int unsigned WORD_W     = 32;

  // Result layout: remainder in the HI half, quotient in the LO half.
  localparam int unsigned RES_QUO_LO = 0;
  localparam int unsigned RES_REM_HI = WORD_W;

  localparam int unsigned DIV_STATE_W = 3;
  localparam logic [2:0] DIV_IDLE = 3'd0;
  localparam logic [2:0] DIV_CALC = 3'd1;
  localparam logic [2:0] DIV_SIGN = 3'd2;
  localparam logic [2:0] DIV_ZERO = 3'd3;
  localparam logic [2:0] DIV_DONE = 3'd4;

endpackage

// File: rtl/div_step.sv
// Purpose: one combinational restoring-division iteration.
// Ports:
//   rem_i, quo_i : partial remainder and quotient/dividend shift register
//   dvs_i        : divisor magnitude
//   rem_o, quo_o : values after shifting left one bit and a trial subtract
module div_step
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_ext;
  logic [WIDTH:0] trial;
  logic           take;

  // The shifted remainder needs WIDTH+1 bits because the divisor magnitude
  // can use the full unsigned range.
  always_comb begin
    rem_ext = {rem_i, quo_i[WIDTH-1]};
    trial   = rem_ext - {1'b0, dvs_i};
    take    = (rem_ext >= {1'b0, dvs_i});
    rem_o   = take ? WIDTH'(trial) : WIDTH'(rem_ext);
    quo_o   = {quo_i[WIDTH-2:0], take};
  end

endmodule

// File: rtl/div_sequencer.sv
// Purpose: multi-cycle signed/unsigned integer divider (DIV/DIVU), one
// restoring step per clock, result returned as {remainder, quotient}.
// Ports:
//   clock, clear          : clock and synchronous active-high reset
//   start, signed_op      : request and signedness, sampled when not busy
//   dividend, divisor     : operands, sampled with an accepted start
//   busy, done            : operation in progress / one-cycle completion pulse
//   div_by_zero, result   : status and {remainder, quotient}, held until next start
module div_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [DIV_STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sop_q, sop_d;
  logic                   sa_q, sa_d;
  logic                   sb_q, sb_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   dbz_q, dbz_d;
  logic [2*WIDTH-1:0]     result_q, result_d;

  logic [WIDTH-1:0]       step_rem;
  logic [WIDTH-1:0]       step_quo;
  logic                   dvd_neg;
  logic                   dvs_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Next-state, datapath and output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    dbz_d    = dbz_q;
    result_d = result_q;
    dvd_neg  = signed_op & dividend[WIDTH-1];
    dvs_neg  = signed_op & divisor[WIDTH-1];

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (start) begin
          sop_d   = signed_op;
          sa_d    = dividend[WIDTH-1];
          sb_d    = divisor[WIDTH-1];
          // Magnitudes are unsigned, so -2^(WIDTH-1) is representable.
          quo_d   = dvd_neg ? -dividend : dividend;
          dvs_d   = dvs_neg ? -divisor : divisor;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = (divisor == '0) ? DIV_ZERO : DIV_CALC;
        end else if (state_q == DIV_DONE) begin
          state_d = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DIV_SIGN;
      end
      DIV_SIGN: begin
        // Quotient sign is the XOR of operand signs; remainder follows dividend.
        result_d = {(sop_q & sa_q) ? -rem_q : rem_q,
                    (sop_q & (sa_q ^ sb_q)) ? -quo_q : quo_q};
        state_d  = DIV_DONE;
      end
      DIV_ZERO: begin
        // Undo the magnitude conversion to return the original dividend.
        result_d = {(sop_q & sa_q) ? -quo_q : quo_q, {WIDTH{1'b1}}};
        dbz_d    = 1'b1;
        state_d  = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase

    busy_d = (state_d == DIV_CALC) || (state_d == DIV_SIGN) || (state_d == DIV_ZERO);
    done_d = (state_d == DIV_DONE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      sop_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign result      = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Purpose: directed self-checking bench for div_sequencer.
module tb_div_sequencer;
  import cpu_pkg::*;

  logic          clock = 1'b0;
  logic          clear;
  logic          start;
  logic          signed_op;
  logic [31:0]   dividend;
  logic [31:0]   divisor;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [63:0]   result;

  int vectors    = 0;
  int miscompares = 0;

  div_sequencer #(.WIDTH(WORD_W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the operand ports.
  task automatic launch(input logic sop, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    signed_op = sop; dividend = a; divisor = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; signed_op = ~sop; dividend = $urandom; divisor = $urandom;
  endtask

  // Count edges since the start edge until done, bounded.
  task automatic wait_done(input int lat0, output int lat, output int busy_cyc);
    lat = lat0; busy_cyc = 0;
    while (!done && lat < 80) begin
      if (busy) busy_cyc++;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic sop, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input int exp_lat, input logic exp_dbz);
    int lat, bc;
    launch(sop, a, b);
    wait_done(1, lat, bc);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_cycles"}, 64'(bc), 64'(exp_lat - 1));
    check({tag, " result"}, result, exp_res);
    check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, bc;
    logic seen;
    logic [31:0] hi, lo;
    clear = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);
    check("reset result", result, 64'd0);
    clear = 1'b0;

    // Basic signed divide and one-cycle done pulse.
    run_op("s100/7", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1'b0);
    @(posedge clock); #1;
    check("done pulse width", 64'(done), 64'd0);
    check("idle after done", 64'(busy), 64'd0);

    // Sign handling.
    run_op("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34, 1'b0);
    run_op("s100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 34, 1'b0);
    run_op("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 34, 1'b0);

    // Most-negative boundary, signed wrap vs unsigned.
    run_op("s_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 1'b0);
    run_op("u_min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 34, 1'b0);
    run_op("u_max/3", 1'b0, 32'hFFFF_FFFF, 32'd3, {32'h0, 32'h5555_5555}, 34, 1'b0);

    // Divide by zero short path, then status cleared by next accepted start.
    run_op("dbz", 1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 2, 1'b1);
    run_op("s_dbz", 1'b1, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 2, 1'b1);

    // Start while busy is ignored.
    launch(1'b0, 32'd50, 32'd5);
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    signed_op = 1'b0; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(5, lat, bc);
    check("ignore latency", 64'(lat), 64'd34);
    check("ignore result", result, {32'd0, 32'd10});
    check("ignore dbz", 64'(div_by_zero), 64'd0);

    // Clear during CALC aborts with no done pulse.
    launch(1'b0, 32'd50, 32'd5);
    repeat (9) begin @(posedge clock); #1; end
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort result", result, 64'd0);
    check("abort dbz", 64'(div_by_zero), 64'd0);
    clear = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clock); #1; seen |= done; end
    check("abort no done", 64'(seen), 64'd0);

    // Clear wins over start on the same edge.
    @(negedge clock);
    clear = 1'b1; start = 1'b1; signed_op = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    clear = 1'b0; start = 1'b0;
    check("clr_prio busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (5) begin @(posedge clock); #1; seen |= done | busy; end
    check("clr_prio idle", 64'(seen), 64'd0);

    // Back-to-back: second start on the done cycle of the first.
    launch(1'b0, 32'd20, 32'd3);
    wait_done(1, lat, bc);
    check("b2b first latency", 64'(lat), 64'd34);
    check("b2b first result", result, {32'd2, 32'd6});
    signed_op = 1'b0; dividend = 32'd7; divisor = 32'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    check("b2b done drops", 64'(done), 64'd0);
    check("b2b busy", 64'(busy), 64'd1);
    wait_done(1, lat, bc);
    check("b2b second latency", 64'(lat), 64'd34);
    hi = result[RES_REM_HI +: WORD_W];
    lo = result[RES_QUO_LO +: WORD_W];
    check("b2b second rem", 64'(hi), 64'd1);
    check("b2b second quo", 64'(lo), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
